dijkstra_engine: RTL and testbench

- Parametrised shortest-path engine; successor to the fixed 37-node direction planner.
- Software or a loader writes a weighted adjacency matrix. A start pulse runs single-source Dijkstra from src to dst with early exit.
- Result is reported as total distance and hop count, and the node path is streamed src-to-dst over a valid/ready port.
- Sits between the map loader and the downstream direction encoder.

---
 rtl/dijkstra_engine.sv | 244 ++++++++++++++++++++++++
 tb/tb_dijkstra_engine.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dijkstra_engine.sv
// Single-source shortest-path engine over a writable adjacency matrix.
// Runs Dijkstra from src to dst, stops as soon as dst is selected, and then
// streams the path src..dst over a valid/ready port.
module dijkstra_engine #(
   parameter int N_NODES = 37,
   parameter int NODE_W  = 6,
   parameter int DIST_W  = 16
) (
   input  logic              clk_50,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [NODE_W-1:0] cfg_src,
   input  logic [NODE_W-1:0] cfg_dst,
   input  logic [DIST_W-1:0] cfg_wt,
   input  logic              start,
   input  logic [NODE_W-1:0] src_node,
   input  logic [NODE_W-1:0] dst_node,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              unreachable,
   output logic [DIST_W-1:0] total_dist,
   output logic [NODE_W-1:0] path_len,
   output logic              path_valid,
   input  logic              path_ready,
   output logic [NODE_W-1:0] path_node,
   output logic              path_last
);

   localparam int IDX_W = (N_NODES > 1) ? $clog2(N_NODES) : 1;
   localparam int ADJ_AW = (N_NODES > 1) ? $clog2(N_NODES * N_NODES) : 1;
   localparam logic [NODE_W-1:0] N_ID = NODE_W'(N_NODES);
   localparam logic [DIST_W-1:0] INF = '1;

   typedef enum logic [2:0] {
      ST_IDLE, ST_CHECK, ST_INIT, ST_SELECT, ST_RELAX, ST_TRACE, ST_STREAM, ST_FIN
   } state_t;

   state_t state_q, state_d;
   logic [NODE_W-1:0] src_q, src_d, dst_q, dst_d;
   logic [NODE_W-1:0] cnt_q, cnt_d;           // scan index, also stream stack index
   logic [NODE_W-1:0] pos_q, pos_d;           // node being relaxed (0-based)
   logic [DIST_W-1:0] pos_dist_q, pos_dist_d;
   logic [DIST_W-1:0] best_dist_q, best_dist_d;
   logic [NODE_W-1:0] best_idx_q, best_idx_d;
   logic [NODE_W-1:0] v_q, v_d;               // trace cursor (1-based)
   logic [NODE_W-1:0] sp_q, sp_d;             // stack write pointer
   logic              ph_q, ph_d;             // trace phase: push / follow prev
   logic              err_q, err_d, unr_q, unr_d;
   logic [DIST_W-1:0] total_q, total_d;
   logic [NODE_W-1:0] len_q, len_d;

   // Storage arrays and their registered read ports
   logic [DIST_W-1:0] adj_mem   [N_NODES*N_NODES];
   logic [DIST_W-1:0] dist_mem  [N_NODES];
   logic [NODE_W-1:0] prev_mem  [N_NODES];
   logic              vis_mem   [N_NODES];
   logic [NODE_W-1:0] stack_mem [N_NODES];
   logic [DIST_W-1:0] adj_rd_q, dist_rd_q;
   logic [NODE_W-1:0] prev_rd_q, stack_rd_q;
   logic              vis_rd_q;

   logic              adj_we, dist_we, prev_we, vis_we, stack_we;
   logic [ADJ_AW-1:0] adj_waddr, adj_raddr;
   logic [IDX_W-1:0]  dist_waddr, dist_raddr, prev_waddr, prev_raddr;
   logic [IDX_W-1:0]  vis_waddr, vis_raddr, stack_waddr, stack_raddr;
   logic [DIST_W-1:0] adj_wdata, dist_wdata;
   logic [NODE_W-1:0] prev_wdata, stack_wdata;
   logic              vis_wdata;

   logic              sel_take, relax_take;
   logic [DIST_W-1:0] sel_dist;
   logic [NODE_W-1:0] sel_idx;
   logic [DIST_W:0]   relax_sum;

   // One extra bit so an overflowing sum can be recognised and rejected
   assign relax_sum = {1'b0, pos_dist_q} + {1'b0, adj_rd_q};

   // Next-state, memory port control and result updates
   always_comb begin
      state_d = state_q;  src_d = src_q;  dst_d = dst_q;  cnt_d = cnt_q;
      pos_d = pos_q;  pos_dist_d = pos_dist_q;
      best_dist_d = best_dist_q;  best_idx_d = best_idx_q;
      v_d = v_q;  sp_d = sp_q;  ph_d = ph_q;
      err_d = err_q;  unr_d = unr_q;  total_d = total_q;  len_d = len_q;
      adj_we = 1'b0;  dist_we = 1'b0;  prev_we = 1'b0;  vis_we = 1'b0;  stack_we = 1'b0;
      adj_waddr = '0;  adj_raddr = '0;  dist_waddr = '0;  dist_raddr = '0;
      prev_waddr = '0;  prev_raddr = '0;  vis_waddr = '0;  vis_raddr = '0;
      stack_waddr = '0;  stack_raddr = '0;
      adj_wdata = cfg_wt;  dist_wdata = INF;  prev_wdata = '0;  stack_wdata = v_q;
      vis_wdata = 1'b0;
      sel_take = 1'b0;  sel_dist = best_dist_q;  sel_idx = best_idx_q;
      relax_take = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cfg_we && cfg_src != '0 && cfg_src <= N_ID && cfg_dst != '0 && cfg_dst <= N_ID) begin
               adj_we    = 1'b1;
               adj_waddr = ADJ_AW'(cfg_src - 1'b1) * ADJ_AW'(N_NODES) + ADJ_AW'(cfg_dst - 1'b1);
            end
            if (start) begin
               src_d = src_node;  dst_d = dst_node;
               err_d = 1'b0;  unr_d = 1'b0;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (src_q == '0 || src_q > N_ID || dst_q == '0 || dst_q > N_ID) begin
               err_d = 1'b1;  total_d = INF;  len_d = '0;
               state_d = ST_FIN;
            end else begin
               cnt_d = '0;
               state_d = ST_INIT;
            end
         end
         ST_INIT: begin
            // One node per cycle; the source gets distance 0 as it is swept
            dist_we = 1'b1;  prev_we = 1'b1;  vis_we = 1'b1;
            dist_waddr = IDX_W'(cnt_q);  prev_waddr = IDX_W'(cnt_q);  vis_waddr = IDX_W'(cnt_q);
            dist_wdata = (cnt_q == src_q - 1'b1) ? '0 : INF;
            if (cnt_q == N_ID - 1'b1) begin
               cnt_d = '0;  best_dist_d = INF;  best_idx_d = '0;
               state_d = ST_SELECT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_SELECT: begin
            // Read node cnt, evaluate node cnt-1 from the previous read
            if (cnt_q < N_ID) begin
               dist_raddr = IDX_W'(cnt_q);  vis_raddr = IDX_W'(cnt_q);
            end
            sel_take = (cnt_q != '0) && !vis_rd_q && (dist_rd_q != INF) && (dist_rd_q < best_dist_q);
            if (sel_take) begin
               sel_dist = dist_rd_q;  sel_idx = cnt_q - 1'b1;
            end
            best_dist_d = sel_dist;  best_idx_d = sel_idx;
            if (cnt_q == N_ID) begin
               cnt_d = '0;
               if (sel_dist == INF) begin
                  unr_d = 1'b1;  total_d = INF;  len_d = '0;
                  state_d = ST_FIN;
               end else if (sel_idx == dst_q - 1'b1) begin
                  total_d = sel_dist;  v_d = dst_q;  sp_d = '0;  ph_d = 1'b0;
                  state_d = ST_TRACE;
               end else begin
                  vis_we = 1'b1;  vis_waddr = IDX_W'(sel_idx);  vis_wdata = 1'b1;
                  pos_d = sel_idx;  pos_dist_d = sel_dist;
                  state_d = ST_RELAX;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RELAX: begin
            // Read edge pos->cnt, relax neighbour cnt-1 from the previous read
            if (cnt_q < N_ID) begin
               adj_raddr  = ADJ_AW'(pos_q) * ADJ_AW'(N_NODES) + ADJ_AW'(cnt_q);
               dist_raddr = IDX_W'(cnt_q);  vis_raddr = IDX_W'(cnt_q);
            end
            relax_take = (cnt_q != '0) && (adj_rd_q != '0) && !vis_rd_q &&
                         (relax_sum < {1'b0, INF}) && (relax_sum[DIST_W-1:0] < dist_rd_q);
            if (relax_take) begin
               dist_we = 1'b1;  dist_waddr = IDX_W'(cnt_q - 1'b1);  dist_wdata = relax_sum[DIST_W-1:0];
               prev_we = 1'b1;  prev_waddr = IDX_W'(cnt_q - 1'b1);  prev_wdata = pos_q + 1'b1;
            end
            if (cnt_q == N_ID) begin
               cnt_d = '0;  best_dist_d = INF;  best_idx_d = '0;
               state_d = ST_SELECT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_TRACE: begin
            if (!ph_q) begin
               stack_we = 1'b1;  stack_waddr = IDX_W'(sp_q);
               prev_raddr = IDX_W'(v_q - 1'b1);
               ph_d = 1'b1;
            end else if (prev_rd_q == '0) begin
               // Top of stack is src; prime the read port for the first beat
               len_d = sp_q + 1'b1;  cnt_d = sp_q;
               stack_raddr = IDX_W'(sp_q);
               state_d = ST_STREAM;
            end else begin
               v_d = prev_rd_q;  sp_d = sp_q + 1'b1;  ph_d = 1'b0;
            end
         end
         ST_STREAM: begin
            // Hold the read address while stalled so path_node stays stable
            stack_raddr = IDX_W'(cnt_q);
            if (path_ready) begin
               if (cnt_q == '0) begin
                  state_d = ST_FIN;
               end else begin
                  cnt_d = cnt_q - 1'b1;
                  stack_raddr = IDX_W'(cnt_q - 1'b1);
               end
            end
         end
         ST_FIN: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and result registers
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;  src_q <= '0;  dst_q <= '0;  cnt_q <= '0;
         pos_q <= '0;  pos_dist_q <= '0;  best_dist_q <= '0;  best_idx_q <= '0;
         v_q <= '0;  sp_q <= '0;  ph_q <= 1'b0;
         err_q <= 1'b0;  unr_q <= 1'b0;  total_q <= '0;  len_q <= '0;
      end else begin
         state_q <= state_d;  src_q <= src_d;  dst_q <= dst_d;  cnt_q <= cnt_d;
         pos_q <= pos_d;  pos_dist_q <= pos_dist_d;  best_dist_q <= best_dist_d;
         best_idx_q <= best_idx_d;  v_q <= v_d;  sp_q <= sp_d;  ph_q <= ph_d;
         err_q <= err_d;  unr_q <= unr_d;  total_q <= total_d;  len_q <= len_d;
      end
   end

   // Block RAMs: not reset, so the adjacency matrix survives rst_n
   always_ff @(posedge clk_50) begin
      if (adj_we)   adj_mem[adj_waddr]     <= adj_wdata;
      if (dist_we)  dist_mem[dist_waddr]   <= dist_wdata;
      if (prev_we)  prev_mem[prev_waddr]   <= prev_wdata;
      if (vis_we)   vis_mem[vis_waddr]     <= vis_wdata;
      if (stack_we) stack_mem[stack_waddr] <= stack_wdata;
      adj_rd_q   <= adj_mem[adj_raddr];
      dist_rd_q  <= dist_mem[dist_raddr];
      prev_rd_q  <= prev_mem[prev_raddr];
      vis_rd_q   <= vis_mem[vis_raddr];
      stack_rd_q <= stack_mem[stack_raddr];
   end

   assign busy        = (state_q != ST_IDLE) && (state_q != ST_FIN);
   assign done        = (state_q == ST_FIN);
   assign err         = err_q;
   assign unreachable = unr_q;
   assign total_dist  = total_q;
   assign path_len    = len_q;
   assign path_valid  = (state_q == ST_STREAM);
   assign path_node   = path_valid ? stack_rd_q : '0;
   assign path_last   = path_valid && (cnt_q == '0);

endmodule

// File: tb/tb_dijkstra_engine.sv
// Self-checking bench for dijkstra_engine with N_NODES=8: directed scenarios
// plus randomized graphs checked against a plain Dijkstra reference model.
module tb_dijkstra_engine;

   localparam int N   = 8;
   localparam int NW  = 6;
   localparam int DW  = 16;
   localparam int INF = 65535;

   logic          clk_50 = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_we = 1'b0;
   logic [NW-1:0] cfg_src = '0, cfg_dst = '0;
   logic [DW-1:0] cfg_wt = '0;
   logic          start = 1'b0;
   logic [NW-1:0] src_node = '0, dst_node = '0;
   logic          busy, done, err, unreachable;
   logic [DW-1:0] total_dist;
   logic [NW-1:0] path_len;
   logic          path_valid;
   logic          path_ready = 1'b1;
   logic [NW-1:0] path_node;
   logic          path_last;

   dijkstra_engine #(.N_NODES(N), .NODE_W(NW), .DIST_W(DW)) dut (
      .clk_50(clk_50), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_src(cfg_src),
      .cfg_dst(cfg_dst), .cfg_wt(cfg_wt), .start(start), .src_node(src_node),
      .dst_node(dst_node), .busy(busy), .done(done), .err(err),
      .unreachable(unreachable), .total_dist(total_dist), .path_len(path_len),
      .path_valid(path_valid), .path_ready(path_ready), .path_node(path_node),
      .path_last(path_last)
   );

   always #10 clk_50 = ~clk_50;

   int checks = 0;
   int errors = 0;
   int shadow [1:N][1:N];

   // Observations of the last run
   int obs_beats[$];
   int obs_lasts[$];
   int obs_done_cnt, obs_done_cyc, obs_stall_bad, obs_last_bad, obs_extra;
   int obs_dist, obs_len;
   bit obs_timeout, obs_busy1, obs_err, obs_unr;

   // Reference results
   int exp_path[$];
   int exp_dist, exp_len;
   bit exp_err, exp_unr;

   task automatic tick();
      @(posedge clk_50);
      #1;
   endtask

   function automatic string qstr(input int q[$]);
      string s = "";
      foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
      return s;
   endfunction

   function automatic bit qeq(input int a[$], input int b[$]);
      if (a.size() != b.size()) return 1'b0;
      foreach (a[i]) if (a[i] != b[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic cfg_write(input int s, input int d, input int w);
      cfg_we = 1'b1;  cfg_src = NW'(s);  cfg_dst = NW'(d);  cfg_wt = DW'(w);
      tick();
      cfg_we = 1'b0;
      if (s >= 1 && s <= N && d >= 1 && d <= N) shadow[s][d] = w;
   endtask

   task automatic add_edge(input int a, input int b, input int w);
      cfg_write(a, b, w);
      cfg_write(b, a, w);
   endtask

   task automatic clear_graph();
      for (int i = 1; i <= N; i++)
         for (int j = 1; j <= N; j++) cfg_write(i, j, 0);
   endtask

   task automatic load_s1();
      clear_graph();
      add_edge(1, 2, 4);  add_edge(1, 3, 1);  add_edge(3, 2, 1);  add_edge(2, 4, 5);
   endtask

   // Textbook Dijkstra over the shadow matrix: lowest index wins ties,
   // sums reaching INF never relax, stop when dst is selected.
   task automatic model_run(input int s, input int d);
      int md[1:N];
      int mp[1:N];
      bit mv[1:N];
      int u, v, alt;
      exp_path.delete();  exp_err = 0;  exp_unr = 0;  exp_dist = INF;  exp_len = 0;
      if (s < 1 || s > N || d < 1 || d > N) begin exp_err = 1; return; end
      for (int k = 1; k <= N; k++) begin md[k] = INF; mp[k] = 0; mv[k] = 0; end
      md[s] = 0;
      while (1) begin
         u = 0;
         for (int k = 1; k <= N; k++)
            if (!mv[k] && md[k] < INF && (u == 0 || md[k] < md[u])) u = k;
         if (u == 0) begin exp_unr = 1; return; end
         if (u == d) break;
         mv[u] = 1;
         for (int k = 1; k <= N; k++) begin
            alt = md[u] + shadow[u][k];
            if (shadow[u][k] != 0 && !mv[k] && alt < INF && alt < md[k]) begin
               md[k] = alt;  mp[k] = u;
            end
         end
      end
      exp_dist = md[d];
      v = d;
      while (v != 0) begin exp_path.push_front(v); v = mp[v]; end
      exp_len = exp_path.size();
   endtask

   // Starts a run and records everything the DUT does until done (bounded).
   // rmode: 0 = always ready, 1 = pattern 1,0,0, 2 = random.
   task automatic run_dut(input int s, input int d, input int rmode, input bit poke);
      int  cyc;
      bit  prev_stall;
      int  prev_node;
      obs_beats.delete();  obs_lasts.delete();
      obs_done_cnt = 0;  obs_done_cyc = 0;  obs_stall_bad = 0;  obs_last_bad = 0;
      obs_extra = 0;  obs_timeout = 1;  prev_stall = 0;  prev_node = 0;
      src_node = NW'(s);  dst_node = NW'(d);  start = 1'b1;
      tick();
      start = 1'b0;
      obs_busy1 = busy;
      for (cyc = 1; cyc < 6000; cyc++) begin
         case (rmode)
            0: path_ready = 1'b1;
            1: path_ready = (cyc % 3 == 0);
            default: path_ready = 1'($urandom_range(0, 1));
         endcase
         if (poke && cyc == 30) begin
            start = 1'b1;  src_node = 2;  dst_node = 3;
            cfg_we = 1'b1;  cfg_src = 1;  cfg_dst = 4;  cfg_wt = 1;
         end else if (poke && cyc == 31) begin
            start = 1'b0;  cfg_we = 1'b0;
         end
         if (prev_stall && (!path_valid || int'(path_node) != prev_node)) obs_stall_bad++;
         if (path_valid && path_ready) begin
            obs_beats.push_back(int'(path_node));
            obs_lasts.push_back(int'(path_last));
         end
         prev_stall = path_valid && !path_ready;
         prev_node  = int'(path_node);
         if (done) begin
            obs_done_cnt++;  obs_done_cyc = cyc;  obs_timeout = 0;
            obs_err = err;  obs_unr = unreachable;
            obs_dist = int'(total_dist);  obs_len = int'(path_len);
            break;
         end
         tick();
      end
      start = 1'b0;  cfg_we = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (done) obs_done_cnt++;
         if (path_valid || busy) obs_extra++;
      end
      foreach (obs_lasts[i])
         if (obs_lasts[i] != ((i == obs_lasts.size() - 1) ? 1 : 0)) obs_last_bad++;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      checks++;
      if ({busy, done, err, unreachable, path_valid, path_last} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags got %b want 000000",
                  {busy, done, err, unreachable, path_valid, path_last});
      end
      checks++;
      if (total_dist !== '0 || path_len !== '0 || path_node !== '0) begin
         errors++;
         $display("FAIL reset_values got dist=%0d len=%0d node=%0d want 0 0 0",
                  total_dist, path_len, path_node);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", busy); end
   endtask

   task automatic test_basic_path();
      int want[$];
      want = '{1, 3, 2, 4};
      load_s1();
      run_dut(1, 4, 0, 0);
      checks++;
      if (obs_timeout) begin errors++; $display("FAIL s1_timeout got no done want done"); end
      checks++;
      if (!qeq(obs_beats, want)) begin
         errors++; $display("FAIL s1_path got %s want %s", qstr(obs_beats), qstr(want));
      end
      checks++;
      if (obs_last_bad != 0) begin errors++; $display("FAIL s1_last got %0d bad beats want 0", obs_last_bad); end
      checks++;
      if (obs_dist != 7 || obs_len != 4) begin
         errors++; $display("FAIL s1_result got dist=%0d len=%0d want 7 4", obs_dist, obs_len);
      end
      checks++;
      if (obs_err || obs_unr || !obs_busy1) begin
         errors++; $display("FAIL s1_flags got err=%0d unr=%0d busy=%0d want 0 0 1", obs_err, obs_unr, obs_busy1);
      end
      checks++;
      if (obs_done_cnt != 1 || obs_extra != 0) begin
         errors++; $display("FAIL s1_done got pulses=%0d extra=%0d want 1 0", obs_done_cnt, obs_extra);
      end
   endtask

   task automatic test_unreachable();
      run_dut(1, 6, 0, 0);
      checks++;
      if (obs_timeout || obs_beats.size() != 0 || obs_done_cnt != 1) begin
         errors++; $display("FAIL unr_run got timeout=%0d beats=%0d done=%0d want 0 0 1",
                            obs_timeout, obs_beats.size(), obs_done_cnt);
      end
      checks++;
      if (!obs_unr || obs_err || obs_dist != INF || obs_len != 0) begin
         errors++; $display("FAIL unr_result got unr=%0d err=%0d dist=%0d len=%0d want 1 0 65535 0",
                            obs_unr, obs_err, obs_dist, obs_len);
      end
   endtask

   task automatic test_err();
      int srcs[2];
      int dsts[2];
      srcs = '{0, 9};  dsts = '{3, 1};
      for (int i = 0; i < 2; i++) begin
         run_dut(srcs[i], dsts[i], 0, 0);
         checks++;
         if (obs_timeout || obs_done_cyc > 3 || obs_beats.size() != 0) begin
            errors++; $display("FAIL err_timing[%0d] got timeout=%0d cyc=%0d beats=%0d want 0 <=3 0",
                               i, obs_timeout, obs_done_cyc, obs_beats.size());
         end
         checks++;
         if (!obs_err || obs_unr || obs_dist != INF || obs_len != 0) begin
            errors++; $display("FAIL err_result[%0d] got err=%0d unr=%0d dist=%0d len=%0d want 1 0 65535 0",
                               i, obs_err, obs_unr, obs_dist, obs_len);
         end
      end
   endtask

   task automatic test_self_path();
      int want[$];
      want = '{5};
      run_dut(5, 5, 0, 0);
      checks++;
      if (!qeq(obs_beats, want) || obs_last_bad != 0) begin
         errors++; $display("FAIL self_path got %s lastbad=%0d want %s", qstr(obs_beats), obs_last_bad, qstr(want));
      end
      checks++;
      if (obs_timeout || obs_dist != 0 || obs_len != 1 || obs_err || obs_unr) begin
         errors++; $display("FAIL self_result got timeout=%0d dist=%0d len=%0d err=%0d unr=%0d want 0 0 1 0 0",
                            obs_timeout, obs_dist, obs_len, obs_err, obs_unr);
      end
   endtask

   task automatic test_back_to_back_stall();
      int want[$];
      want = '{1, 3, 2, 4};
      run_dut(1, 4, 1, 1);
      checks++;
      if (!qeq(obs_beats, want) || obs_stall_bad != 0) begin
         errors++; $display("FAIL stall_path got %s stallbad=%0d want %s 0", qstr(obs_beats), obs_stall_bad, qstr(want));
      end
      checks++;
      if (obs_timeout || obs_dist != 7 || obs_done_cnt != 1 || obs_extra != 0) begin
         errors++; $display("FAIL stall_result got timeout=%0d dist=%0d done=%0d extra=%0d want 0 7 1 0",
                            obs_timeout, obs_dist, obs_done_cnt, obs_extra);
      end
      // The mid-run write of 1->4 w1 must have been dropped
      run_dut(1, 4, 0, 0);
      checks++;
      if (!qeq(obs_beats, want) || obs_dist != 7) begin
         errors++; $display("FAIL frozen_adj got %s dist=%0d want %s 7", qstr(obs_beats), obs_dist, qstr(want));
      end
   endtask

   task automatic test_ties_overflow();
      int want[$];
      want = '{1, 2, 4};
      clear_graph();
      add_edge(1, 2, 16'hFFFE);  add_edge(2, 3, 5);
      run_dut(1, 3, 0, 0);
      checks++;
      if (obs_timeout || !obs_unr || obs_dist != INF || obs_beats.size() != 0) begin
         errors++; $display("FAIL overflow got timeout=%0d unr=%0d dist=%0d beats=%0d want 0 1 65535 0",
                            obs_timeout, obs_unr, obs_dist, obs_beats.size());
      end
      clear_graph();
      add_edge(1, 2, 1);  add_edge(1, 3, 1);  add_edge(2, 4, 1);  add_edge(3, 4, 1);
      run_dut(1, 4, 0, 0);
      checks++;
      if (!qeq(obs_beats, want) || obs_dist != 2 || obs_len != 3) begin
         errors++; $display("FAIL tie got %s dist=%0d len=%0d want %s 2 3", qstr(obs_beats), obs_dist, obs_len, qstr(want));
      end
   endtask

   task automatic test_reset_midrun();
      int want[$];
      want = '{1, 3, 2, 4};
      load_s1();
      src_node = 1;  dst_node = 4;  start = 1'b1;
      tick();
      start = 1'b0;
      repeat (21) tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, err, unreachable, path_valid, path_last} !== 6'b0 ||
          total_dist !== '0 || path_len !== '0 || path_node !== '0) begin
         errors++; $display("FAIL midrun_reset got busy=%b done=%b dist=%0d len=%0d want all 0",
                            busy, done, total_dist, path_len);
      end
      @(posedge clk_50);
      @(posedge clk_50);
      #1;
      rst_n = 1'b1;
      tick();
      run_dut(1, 4, 0, 0);
      checks++;
      if (obs_timeout || !qeq(obs_beats, want) || obs_dist != 7 || obs_len != 4) begin
         errors++; $display("FAIL post_reset got %s dist=%0d len=%0d want %s 7 4",
                            qstr(obs_beats), obs_dist, obs_len, qstr(want));
      end
   endtask

   task automatic test_random();
      int s, d, w, r;
      for (int it = 0; it < 12; it++) begin
         for (int i = 1; i <= N; i++)
            for (int j = 1; j <= N; j++) begin
               r = $urandom_range(0, 99);
               if (r < 55) w = 0;
               else if (r < 63) w = $urandom_range(16'hFFF0, 16'hFFFE);
               else w = $urandom_range(1, 20);
               cfg_write(i, j, w);
            end
         cfg_write(1, 9, 1);   // out of range, must be dropped
         s = $urandom_range(1, N);
         d = $urandom_range(1, N);
         if (it % 6 == 5) s = (it == 5) ? 0 : 9;
         model_run(s, d);
         run_dut(s, d, 2, 0);
         checks++;
         if (obs_timeout || obs_done_cnt != 1) begin
            errors++; $display("FAIL rnd%0d_done got timeout=%0d pulses=%0d want 0 1", it, obs_timeout, obs_done_cnt);
         end
         checks++;
         if (obs_err != exp_err || obs_unr != exp_unr || obs_dist != exp_dist || obs_len != exp_len) begin
            errors++; $display("FAIL rnd%0d_result src=%0d dst=%0d got err=%0d unr=%0d dist=%0d len=%0d want %0d %0d %0d %0d",
                               it, s, d, obs_err, obs_unr, obs_dist, obs_len, exp_err, exp_unr, exp_dist, exp_len);
         end
         checks++;
         if (!qeq(obs_beats, exp_path) || obs_last_bad != 0 || obs_stall_bad != 0) begin
            errors++; $display("FAIL rnd%0d_path got %s lastbad=%0d stallbad=%0d want %s",
                               it, qstr(obs_beats), obs_last_bad, obs_stall_bad, qstr(exp_path));
         end
      end
   endtask

   initial begin
      for (int i = 1; i <= N; i++)
         for (int j = 1; j <= N; j++) shadow[i][j] = 0;
      test_reset();
      test_basic_path();
      test_unreachable();
      test_err();
      test_self_path();
      test_back_to_back_stall();
      test_ties_overflow();
      test_reset_midrun();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
